// File: rtl/mod10_pkg.sv
// Shared types and constants for the mod-10 counter controller and its arbiter.
package mod10_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        CHECK = 2'd3
    } state_e;

    localparam int unsigned MOD     = 10;
    localparam logic [3:0]  MAX_VAL = 4'd9;

    // Value a mod-10 counter reaches from data after len steps; len is at most 8 bits wide.
    function automatic logic [3:0] mod10_expected(input logic [3:0] data,
                                                  input logic [7:0] len,
                                                  input logic       up);
        logic [3:0] step;
        logic [4:0] sum;
        step = 4'(len % 8'd10);
        if (up) begin
            sum = {1'b0, data} + {1'b0, step};
        end else begin
            sum = {1'b0, data} + 5'd10 - {1'b0, step};
        end
        if (sum >= 5'(MOD)) begin
            sum = sum - 5'(MOD);
        end else begin
            sum = sum;
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/mod10_rr_arb.sv
// Two-way round-robin grant with a priority pointer that flips to the requester not served last.
module mod10_rr_arb (
    input  logic       clock,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    // ptr_q = 0 gives requester 0 priority on contention
    logic ptr_q;

    // Grant decode: single valid wins outright, contention follows the pointer
    always_comb begin
        if (!en_i) begin
            grant_o = 2'b00;
        end else if (valid_i == 2'b11) begin
            grant_o = ptr_q ? 2'b10 : 2'b01;
        end else begin
            grant_o = valid_i;
        end
    end

    // Pointer update on every grant
    always_ff @(posedge clock) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (grant_o != 2'b00) begin
            ptr_q <= ~grant_o[1];
        end
    end

endmodule

// File: rtl/mod10_ctrl_arb.sv
// Run-length controller for an external mod-10 counter shared by two requesters.
// Build option: define MOD10_CTRL_ARB_CHECK_EN to compare the counter result against the expected value.
module mod10_ctrl_arb
    import mod10_pkg::*;
#(
    parameter int unsigned LEN_W = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic             req0_mode,
    input  logic [3:0]       req0_data,
    input  logic [LEN_W-1:0] req0_len,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic             req1_mode,
    input  logic [3:0]       req1_data,
    input  logic [LEN_W-1:0] req1_len,
    output logic             cnt_load,
    output logic             cnt_mode,
    output logic [3:0]       cnt_data_in,
    input  logic [3:0]       cnt_data_out,
    output logic             done0,
    output logic             done1,
    output logic [3:0]       result,
    output logic             mismatch,
    output logic             range_err,
    output logic             busy,
    output logic             owner
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, run_cnt_q, run_cnt_d;
    logic [3:0]       data_q, result_q;
    logic             mode_q, owner_q, cnt_mode_q, mismatch_q, range_err_q;
    logic [1:0]       done_q;

    logic             arb_en_s, hs_s, sel_idx_s, sel_mode_s, sel_bad_s, chk_mismatch_s;
    logic [1:0]       grant_s;
    logic [3:0]       sel_data_s;
    logic [LEN_W-1:0] sel_len_s;

    assign arb_en_s = (state_q == IDLE) && !rst;

    mod10_rr_arb u_arb (
        .clock   (clock),
        .rst     (rst),
        .en_i    (arb_en_s),
        .valid_i ({req1_valid, req0_valid}),
        .grant_o (grant_s)
    );

    assign req0_ready = grant_s[0];
    assign req1_ready = grant_s[1];

    // Mux the granted requester's command and flag out-of-range load values
    always_comb begin
        hs_s      = grant_s[0] | grant_s[1];
        sel_idx_s = grant_s[1];
        if (grant_s[1]) begin
            sel_data_s = req1_data;
            sel_mode_s = req1_mode;
            sel_len_s  = req1_len;
        end else begin
            sel_data_s = req0_data;
            sel_mode_s = req0_mode;
            sel_len_s  = req0_len;
        end
        sel_bad_s = hs_s && (sel_data_s > MAX_VAL);
    end

`ifdef MOD10_CTRL_ARB_CHECK_EN
    logic [3:0] expected_s;
    assign expected_s     = mod10_expected(data_q, 8'(len_q), mode_q);
    assign chk_mismatch_s = (cnt_data_out != expected_s);
`else
    assign chk_mismatch_s = 1'b0;
`endif

    // State and run-length counter registers
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= IDLE;
            run_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    // Next-state logic; a rejected (out-of-range) command never leaves IDLE
    always_comb begin
        state_d   = state_q;
        run_cnt_d = run_cnt_q;
        case (state_q)
            IDLE: begin
                if (hs_s && !sel_bad_s) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (len_q == '0) begin
                    state_d = CHECK;
                end else begin
                    state_d   = RUN;
                    run_cnt_d = len_q;
                end
            end
            RUN: begin
                run_cnt_d = run_cnt_q - LEN_W'(1'b1);
                if (run_cnt_q <= LEN_W'(1'b1)) begin
                    state_d = CHECK;
                end else begin
                    state_d = RUN;
                end
            end
            CHECK:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter-side outputs decoded from the current state
    always_comb begin
        cnt_load    = 1'b0;
        cnt_data_in = 4'd0;
        busy        = 1'b1;
        case (state_q)
            IDLE: busy = 1'b0;
            LOAD: begin
                cnt_load    = 1'b1;
                cnt_data_in = data_q;
            end
            RUN:     busy = 1'b1;
            CHECK:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Command capture, completion pulses and sticky status
    always_ff @(posedge clock) begin
        if (rst) begin
            data_q      <= 4'd0;
            mode_q      <= 1'b0;
            len_q       <= '0;
            owner_q     <= 1'b0;
            cnt_mode_q  <= 1'b0;
            result_q    <= 4'd0;
            mismatch_q  <= 1'b0;
            range_err_q <= 1'b0;
            done_q      <= 2'b00;
        end else begin
            done_q <= 2'b00;
            if (hs_s) begin
                data_q  <= sel_data_s;
                mode_q  <= sel_mode_s;
                len_q   <= sel_len_s;
                owner_q <= sel_idx_s;
            end
            // cnt_mode only follows commands that actually reach the counter
            if (hs_s && !sel_bad_s) begin
                cnt_mode_q <= sel_mode_s;
            end
            if (sel_bad_s) begin
                done_q      <= sel_idx_s ? 2'b10 : 2'b01;
                range_err_q <= 1'b1;
                mismatch_q  <= 1'b0;
            end else if (state_q == CHECK) begin
                done_q      <= owner_q ? 2'b10 : 2'b01;
                result_q    <= cnt_data_out;
                mismatch_q  <= chk_mismatch_s;
                range_err_q <= 1'b0;
            end
        end
    end

    assign cnt_mode  = cnt_mode_q;
    assign done0     = done_q[0];
    assign done1     = done_q[1];
    assign result    = result_q;
    assign mismatch  = mismatch_q;
    assign range_err = range_err_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mod10_ctrl_arb.sv
// Self-checking bench: command table with scoreboard queue, plus arbitration and reset sequences.
module tb_mod10_ctrl_arb;

    typedef struct {
        logic       port;
        logic [3:0] data;
        logic       mode;
        logic [3:0] len;
        logic       frc;
        logic [3:0] exp_res;
        logic       exp_mm;
        logic       exp_rng;
        int         exp_lat;
    } vec_t;

`ifdef MOD10_CTRL_ARB_CHECK_EN
    localparam logic FORCE_MM = 1'b1;
`else
    localparam logic FORCE_MM = 1'b0;
`endif

    logic       clock, rst;
    logic       req0_valid, req0_ready, req0_mode;
    logic [3:0] req0_data, req0_len;
    logic       req1_valid, req1_ready, req1_mode;
    logic [3:0] req1_data, req1_len;
    logic       cnt_load, cnt_mode;
    logic [3:0] cnt_data_in, cnt_data_out, cnt_q;
    logic       done0, done1, mismatch, range_err, busy, owner;
    logic [3:0] result;
    logic       force_en;

    int   n_tests, n_fail;
    vec_t vecs[13];
    vec_t sb_q[$];

    mod10_ctrl_arb #(.LEN_W(4)) dut (
        .clock        (clock),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_mode    (req0_mode),
        .req0_data    (req0_data),
        .req0_len     (req0_len),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_mode    (req1_mode),
        .req1_data    (req1_data),
        .req1_len     (req1_len),
        .cnt_load     (cnt_load),
        .cnt_mode     (cnt_mode),
        .cnt_data_in  (cnt_data_in),
        .cnt_data_out (cnt_data_out),
        .done0        (done0),
        .done1        (done1),
        .result       (result),
        .mismatch     (mismatch),
        .range_err    (range_err),
        .busy         (busy),
        .owner        (owner)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural mod-10 up/down counter driven by the controller
    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (cnt_load) begin
            cnt_q <= cnt_data_in;
        end else if (cnt_mode) begin
            cnt_q <= (cnt_q >= 4'd9) ? 4'd0 : cnt_q + 4'd1;
        end else begin
            cnt_q <= (cnt_q == 4'd0 || cnt_q > 4'd9) ? 4'd9 : cnt_q - 4'd1;
        end
    end
    assign cnt_data_out = force_en ? 4'd4 : cnt_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [17:0] all_outs();
        return {req0_ready, req1_ready, cnt_load, cnt_mode, cnt_data_in, done0, done1,
                result, mismatch, range_err, busy, owner};
    endfunction

    // Wait (bounded) for a done pulse, sampling at negedges
    task automatic wait_done(output logic seen);
        int n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 64) begin
            @(negedge clock);
            if (done0 || done1) seen = 1'b1;
            n++;
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int   cyc, lat;
        logic seen, load_seen, rdy;
        vec_t e;
        @(negedge clock);
        force_en = v.frc;
        if (v.port) begin
            req1_valid = 1'b1; req1_data = v.data; req1_mode = v.mode; req1_len = v.len;
        end else begin
            req0_valid = 1'b1; req0_data = v.data; req0_mode = v.mode; req0_len = v.len;
        end
        #1;
        cyc = 0;
        rdy = v.port ? req1_ready : req0_ready;
        while (!rdy && cyc < 32) begin
            @(negedge clock);
            #1;
            rdy = v.port ? req1_ready : req0_ready;
            cyc++;
        end
        chk("grant_wait", 32'(rdy), 32'd1);
        if (!rdy) begin
            req0_valid = 1'b0; req1_valid = 1'b0; force_en = 1'b0;
            return;
        end
        @(posedge clock);
        sb_q.push_back(v);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        lat = 0; seen = 1'b0; load_seen = 1'b0;
        while (!seen && lat < 64) begin
            @(negedge clock);
            if (cnt_load) load_seen = 1'b1;
            if (done0 || done1) begin
                seen = 1'b1;
            end else begin
                @(posedge clock);
                lat++;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        e = sb_q.pop_front();
        if (seen) begin
            chk("done_owner", {30'd0, done1, done0}, e.port ? 32'd2 : 32'd1);
            chk("owner", 32'(owner), 32'(e.port));
            chk("result", 32'(result), 32'(e.exp_res));
            chk("mismatch", 32'(mismatch), 32'(e.exp_mm));
            chk("range_err", 32'(range_err), 32'(e.exp_rng));
            chk("latency", 32'(lat), 32'(e.exp_lat));
            chk("cnt_load_seen", 32'(load_seen), 32'(!e.exp_rng));
            @(negedge clock);
            chk("done_width", {30'd0, done1, done0}, 32'd0);
        end
        force_en = 1'b0;
    endtask

    initial begin
        logic seen;
        int   ndone;
        n_tests = 0; n_fail = 0;
        rst = 1'b1; force_en = 1'b0;
        req0_valid = 1'b0; req0_mode = 1'b0; req0_data = 4'd0; req0_len = 4'd0;
        req1_valid = 1'b0; req1_mode = 1'b0; req1_data = 4'd0; req1_len = 4'd0;

        //         port  data   mode  len    frc   res    mm        rng   lat
        vecs[0]  = '{1'b0, 4'd3,  1'b1, 4'd4,  1'b0, 4'd7, 1'b0,     1'b0, 6};
        vecs[1]  = '{1'b1, 4'd2,  1'b0, 4'd5,  1'b0, 4'd7, 1'b0,     1'b0, 7};
        vecs[2]  = '{1'b0, 4'd12, 1'b1, 4'd3,  1'b0, 4'd7, 1'b0,     1'b1, 0};
        vecs[3]  = '{1'b1, 4'd9,  1'b1, 4'd0,  1'b1, 4'd4, FORCE_MM, 1'b0, 2};
        vecs[4]  = '{1'b0, 4'd0,  1'b0, 4'd1,  1'b0, 4'd9, 1'b0,     1'b0, 3};
        vecs[5]  = '{1'b1, 4'd7,  1'b1, 4'd15, 1'b0, 4'd2, 1'b0,     1'b0, 17};
        vecs[6]  = '{1'b0, 4'd5,  1'b0, 4'd13, 1'b0, 4'd2, 1'b0,     1'b0, 15};
        vecs[7]  = '{1'b1, 4'd9,  1'b1, 4'd3,  1'b0, 4'd2, 1'b0,     1'b0, 5};
        vecs[8]  = '{1'b0, 4'd10, 1'b0, 4'd2,  1'b0, 4'd2, 1'b0,     1'b1, 0};
        vecs[9]  = '{1'b1, 4'd4,  1'b1, 4'd10, 1'b0, 4'd4, 1'b0,     1'b0, 12};
        vecs[10] = '{1'b0, 4'd1,  1'b0, 4'd0,  1'b0, 4'd1, 1'b0,     1'b0, 2};
        vecs[11] = '{1'b1, 4'd8,  1'b0, 4'd9,  1'b0, 4'd9, 1'b0,     1'b0, 11};
        vecs[12] = '{1'b1, 4'd15, 1'b0, 4'd0,  1'b0, 4'd9, 1'b0,     1'b1, 0};

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", 32'(all_outs()), 32'd0);
        rst = 1'b0;

        // Contention straight after reset: req0, then req1, then req0 again
        @(negedge clock);
        req0_data = 4'd1; req0_mode = 1'b1; req0_len = 4'd0;
        req1_data = 4'd2; req1_mode = 1'b1; req1_len = 4'd0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rr_first_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        @(posedge clock);
        #1;
        chk("ready_busy_after_hs", {29'd0, req0_ready, req1_ready, busy}, 32'd1);
        wait_done(seen);
        chk("rr_first_done", {30'd0, done1, done0}, 32'd1);
        chk("rr_first_result", 32'(result), 32'd1);
        chk("rr_second_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
        @(posedge clock);
        #1;
        wait_done(seen);
        chk("rr_second_done", {30'd0, done1, done0}, 32'd2);
        chk("rr_second_result", 32'(result), 32'd2);
        chk("rr_third_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i]);
        end

        // Reset in the middle of a long RUN aborts the command silently
        @(negedge clock);
        req0_data = 4'd3; req0_mode = 1'b1; req0_len = 4'd8; req0_valid = 1'b1;
        @(posedge clock);
        #1;
        req0_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("busy_mid_run", {30'd0, busy, cnt_load}, 32'd2);
        rst = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("abort_outputs", 32'(all_outs()), 32'd0);
        rst = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clock);
            if (done0 || done1) ndone++;
        end
        chk("abort_no_done", 32'(ndone), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mod10_ctrl_arb.md
MOD10_CTRL_ARB -- requirements
Module: mod10_ctrl_arb

Interface
REQ-001 SHALL have parameter: LEN_W, 4, width of run-length fields (range 1..8).
REQ-002 SHALL have port: clock  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0_valid/req1_valid  input  1  request valid per requester.
REQ-005 SHALL have ports: req0_ready/req1_ready  output  1  request accepted this cycle (valid&ready = handshake).
REQ-006 SHALL have ports: req0_mode/req1_mode  input  1  1 = count up, 0 = count down.
REQ-007 SHALL have ports: req0_data/req1_data  input  4  counter load value.
REQ-008 SHALL have ports: req0_len/req1_len  input  LEN_W  counting cycles after load.
REQ-009 SHALL have ports: cnt_load  output  1, cnt_mode  output  1, cnt_data_in  output  4  drive to mod-10 counter.
REQ-010 SHALL have port: cnt_data_out  input  4  counter value.
REQ-011 SHALL have ports: done0/done1  output  1  one-cycle completion pulse to owning requester.
REQ-012 SHALL have ports: result  output  4, mismatch  output  1, range_err  output  1, busy  output  1, owner  output  1.

Function
REQ-013 SHALL implement FSM IDLE, LOAD, RUN, CHECK.
REQ-014 SHALL, in IDLE only, assert reqN_ready combinationally for exactly one valid requester; ready SHALL be 0 in all other states.
REQ-015 SHALL arbitrate round-robin: both valid -> grant requester not granted last; single valid -> grant it.
REQ-016 SHALL, on handshake, capture mode, data, len, owner; busy=1 from the next cycle until return to IDLE.
REQ-017 SHALL, if captured data>9, skip LOAD/RUN/CHECK, stay IDLE, and pulse doneN with range_err=1, mismatch=0 next cycle; cnt_load never asserted.
REQ-018 SHALL, in LOAD (1 cycle), drive cnt_load=1, cnt_data_in=data, cnt_mode=mode.
REQ-019 SHALL, in RUN, hold cnt_load=0, cnt_mode=mode for exactly len cycles; len=0 goes LOAD->CHECK.
REQ-020 SHALL, in CHECK (1 cycle), sample cnt_data_out into result and compute expected = (data + len) mod 10 (up) or (data - len) mod 10 (down), valid for any LEN_W.
REQ-021 SHALL register doneN, result, mismatch on CHECK exit; visible in the following IDLE cycle, pulses 1 cycle wide.
REQ-022 SHALL hold cnt_mode at last value and cnt_load=0 while IDLE; a new grant is possible in the same cycle a done pulse is visible.
REQ-023 SHALL keep result/mismatch/range_err stable until the next done pulse.

Reset
REQ-024 SHALL, with rst=1 at a posedge (any state, including mid-RUN), go to IDLE; all outputs 0; round-robin pointer favours req0; no done pulse for the aborted command.

Configuration
REQ-025 SHALL, with MOD10_CTRL_ARB_CHECK_EN defined, drive mismatch = (result != expected) on CHECK exit.
REQ-026 SHALL, without MOD10_CTRL_ARB_CHECK_EN, omit the expected-value logic, tie mismatch=0, and keep CHECK timing and result capture unchanged.

Structure
REQ-027 SHALL place state enum (IDLE/LOAD/RUN/CHECK), MOD=10 and MAX_VAL=9 in a shared package mod10_pkg.
REQ-028 SHALL use one sub-module mod10_rr_arb (2-way round-robin grant + pointer); the FSM stays in the top.

Verification
REQ-029 SHALL cover: req0 data=3 mode=1 len=4 -> load 3, result=7, mismatch=0, done0 6 cycles after handshake.
REQ-030 SHALL cover: req1 data=2 mode=0 len=5 -> down-wrap, result=7, done1, mismatch=0.
REQ-031 SHALL cover: both valid after reset, held -> req0 granted first, req1 second; next contention grants opposite of last.
REQ-032 SHALL cover: req0 data=12 -> no cnt_load, next cycle done0=1, range_err=1.
REQ-033 SHALL cover: rst asserted during RUN (len=8) -> next cycle IDLE, all outputs 0, no done.
REQ-034 SHALL cover: data=9 mode=1 len=0 with counter model forcing cnt_data_out=4 -> result=4, mismatch=1 (CHECK_EN) / 0 (without).
